// File: rtl/systolic_pe_pkg.sv
// Shared definitions for the systolic processing element.
//   pe_state_t         : PE controller states (IDLE, ACCUM, DRAIN)
//   DEFAULT_DATA_WIDTH : default operand width of the A/B paths
//   DEFAULT_ACC_WIDTH  : default accumulator / C-path width
package systolic_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ACC_WIDTH  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } pe_state_t;

endpackage

// File: rtl/systolic_pe_sat_add.sv
// Combinational accumulator adder with overflow detection.
// The result either clamps to the representable range or wraps,
// depending on SATURATE.
//   a, b : WIDTH-bit addends (two's complement when SIGNED=1)
//   sum  : WIDTH-bit clamped or wrapped result
//   ovf  : high when the true sum does not fit in WIDTH bits
module pe_sat_add #(
  parameter int WIDTH    = 32,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH:0]   ext_sum;
  logic [WIDTH-1:0] raw;
  logic             signed_ovf;
  logic             carry;
  logic [WIDTH-1:0] sat_value;

  assign ext_sum = {1'b0, a} + {1'b0, b};
  assign raw     = ext_sum[WIDTH-1:0];
  assign carry   = ext_sum[WIDTH];

  // Two's-complement overflow: equal operand signs, result sign differs.
  assign signed_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);

  // Overflow detection and clamp value selection.
  always_comb begin
    ovf = (SIGNED != 0) ? signed_ovf : carry;
    if (SIGNED != 0) begin
      // The overflow direction follows the (shared) operand sign.
      if (a[WIDTH-1]) begin
        sat_value = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        sat_value = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end else begin
      sat_value = {WIDTH{1'b1}};
    end
    if ((SATURATE != 0) && ovf) begin
      sum = sat_value;
    end else begin
      sum = raw;
    end
  end

endmodule

// File: rtl/systolic_pe.sv
// Systolic-array processing element: multiply-accumulate of streaming
// A/B operands with registered pass-through, and a drain phase that emits
// the local result followed by CHAIN_POS forwarded upstream results.
//   clk, rst                  : clock, asynchronous active-low reset
//   a_in/a_valid_in           : row operand in, forwarded as a_out/a_valid_out
//   b_in/b_valid_in           : column operand in, forwarded as b_out/b_valid_out
//   acc_clr                   : current MAC loads the product instead of adding
//   drain                     : pulse that starts the result drain
//   c_in/c_valid_in           : upstream drain data
//   c_out/c_valid_out         : drain output
//   ovf                       : sticky accumulator overflow flag
//   busy                      : high while draining
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH,
  parameter int SIGNED     = 1,
  parameter int SATURATE   = 1,
  parameter int CHAIN_POS  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic                  a_valid_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  b_valid_in,
  input  logic                  acc_clr,
  input  logic                  drain,
  input  logic [ACC_WIDTH-1:0]  c_in,
  input  logic                  c_valid_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic                  a_valid_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  b_valid_out,
  output logic [ACC_WIDTH-1:0]  c_out,
  output logic                  c_valid_out,
  output logic                  ovf,
  output logic                  busy
);

  localparam int CNT_W = (CHAIN_POS > 0) ? $clog2(CHAIN_POS + 1) : 1;

  pe_state_t            state, state_nxt;
  logic [ACC_WIDTH-1:0] acc, acc_nxt;
  logic                 ovf_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [ACC_WIDTH-1:0] c_out_nxt;
  logic                 c_valid_nxt;

  logic                 mac;
  logic [ACC_WIDTH-1:0] a_ext, b_ext, product;
  logic [ACC_WIDTH-1:0] add_sum;
  logic                 add_ovf;
  logic [ACC_WIDTH-1:0] acc_mac;
  logic                 ovf_mac;

  assign mac  = a_valid_in & b_valid_in & (state != DRAIN);
  assign busy = (state == DRAIN);

  // Operand extension to accumulator width. The low ACC_WIDTH bits of the
  // extended product equal the exact 2*DATA_WIDTH product, extended.
  always_comb begin
    if (SIGNED != 0) begin
      a_ext = {{(ACC_WIDTH-DATA_WIDTH){a_in[DATA_WIDTH-1]}}, a_in};
      b_ext = {{(ACC_WIDTH-DATA_WIDTH){b_in[DATA_WIDTH-1]}}, b_in};
    end else begin
      a_ext = {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, a_in};
      b_ext = {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, b_in};
    end
    product = a_ext * b_ext;
  end

  pe_sat_add #(
    .WIDTH    (ACC_WIDTH),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_add (
    .a   (acc),
    .b   (product),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // A product load can never overflow, so acc_clr clears the sticky flag.
  assign acc_mac = acc_clr ? product : add_sum;
  assign ovf_mac = acc_clr ? 1'b0 : (ovf | add_ovf);

  // Operand pass-through registers, active in every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_out       <= {DATA_WIDTH{1'b0}};
      a_valid_out <= 1'b0;
      b_out       <= {DATA_WIDTH{1'b0}};
      b_valid_out <= 1'b0;
    end else begin
      a_out       <= a_in;
      a_valid_out <= a_valid_in;
      b_out       <= b_in;
      b_valid_out <= b_valid_in;
    end
  end

  // Controller, accumulator and drain-counter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      acc         <= {ACC_WIDTH{1'b0}};
      ovf         <= 1'b0;
      cnt         <= {CNT_W{1'b0}};
      c_out       <= {ACC_WIDTH{1'b0}};
      c_valid_out <= 1'b0;
    end else begin
      state       <= state_nxt;
      acc         <= acc_nxt;
      ovf         <= ovf_nxt;
      cnt         <= cnt_nxt;
      c_out       <= c_out_nxt;
      c_valid_out <= c_valid_nxt;
    end
  end

  // Next-state logic: MAC, drain start, and forwarding of upstream results.
  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    ovf_nxt     = ovf;
    cnt_nxt     = cnt;
    c_out_nxt   = c_out;
    c_valid_nxt = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        if (mac) begin
          acc_nxt = acc_mac;
          ovf_nxt = ovf_mac;
        end else begin
          acc_nxt = acc;
          ovf_nxt = ovf;
        end
        // A coincident MAC lands first, so the drained value includes it.
        if (drain) begin
          state_nxt   = DRAIN;
          cnt_nxt     = CNT_W'(CHAIN_POS);
          c_out_nxt   = acc_nxt;
          c_valid_nxt = 1'b1;
        end else if (mac) begin
          state_nxt = ACCUM;
        end else begin
          state_nxt = state;
        end
      end
      DRAIN: begin
        if (cnt != {CNT_W{1'b0}}) begin
          cnt_nxt     = cnt - CNT_W'(1);
          c_out_nxt   = c_in;
          c_valid_nxt = c_valid_in;
        end else begin
          state_nxt = IDLE;
          acc_nxt   = {ACC_WIDTH{1'b0}};
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_systolic_pe.sv
// Directed self-checking bench for systolic_pe. Five instances with
// different parameter sets share one input stimulus; each scenario checks
// the instance relevant to it.
//   u0: defaults (signed, saturate, ACC 32, CHAIN_POS 0)
//   u1: unsigned, ACC 32
//   u2: ACC 16, saturate
//   u3: ACC 16, wrap
//   u4: CHAIN_POS 2
module tb_systolic_pe;

  logic        clk;
  logic        rst;
  logic [7:0]  a_in, b_in;
  logic        a_valid_in, b_valid_in, acc_clr, drain, c_valid_in;
  logic [31:0] c_in;

  logic [7:0]  a_out0, b_out0, a_out1, b_out1, a_out2, b_out2, a_out3, b_out3, a_out4, b_out4;
  logic        a_valid_out0, b_valid_out0, a_valid_out1, b_valid_out1, a_valid_out2, b_valid_out2;
  logic        a_valid_out3, b_valid_out3, a_valid_out4, b_valid_out4;
  logic [31:0] c_out0, c_out1, c_out4;
  logic [15:0] c_out2, c_out3;
  logic        c_valid_out0, c_valid_out1, c_valid_out2, c_valid_out3, c_valid_out4;
  logic        ovf0, ovf1, ovf2, ovf3, ovf4;
  logic        busy0, busy1, busy2, busy3, busy4;

  logic [52:0] outs0, outs4;
  assign outs0 = {a_out0, a_valid_out0, b_out0, b_valid_out0, c_out0, c_valid_out0, ovf0, busy0};
  assign outs4 = {a_out4, a_valid_out4, b_out4, b_valid_out4, c_out4, c_valid_out4, ovf4, busy4};

  int total = 0;
  int bad   = 0;

  systolic_pe u0 (
    .clk(clk), .rst(rst), .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in), .b_valid_in(b_valid_in),
    .acc_clr(acc_clr), .drain(drain), .c_in(c_in), .c_valid_in(c_valid_in),
    .a_out(a_out0), .a_valid_out(a_valid_out0), .b_out(b_out0), .b_valid_out(b_valid_out0),
    .c_out(c_out0), .c_valid_out(c_valid_out0), .ovf(ovf0), .busy(busy0));

  systolic_pe #(.SIGNED(0)) u1 (
    .clk(clk), .rst(rst), .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in), .b_valid_in(b_valid_in),
    .acc_clr(acc_clr), .drain(drain), .c_in(c_in), .c_valid_in(c_valid_in),
    .a_out(a_out1), .a_valid_out(a_valid_out1), .b_out(b_out1), .b_valid_out(b_valid_out1),
    .c_out(c_out1), .c_valid_out(c_valid_out1), .ovf(ovf1), .busy(busy1));

  systolic_pe #(.ACC_WIDTH(16), .SATURATE(1)) u2 (
    .clk(clk), .rst(rst), .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in), .b_valid_in(b_valid_in),
    .acc_clr(acc_clr), .drain(drain), .c_in(c_in[15:0]), .c_valid_in(c_valid_in),
    .a_out(a_out2), .a_valid_out(a_valid_out2), .b_out(b_out2), .b_valid_out(b_valid_out2),
    .c_out(c_out2), .c_valid_out(c_valid_out2), .ovf(ovf2), .busy(busy2));

  systolic_pe #(.ACC_WIDTH(16), .SATURATE(0)) u3 (
    .clk(clk), .rst(rst), .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in), .b_valid_in(b_valid_in),
    .acc_clr(acc_clr), .drain(drain), .c_in(c_in[15:0]), .c_valid_in(c_valid_in),
    .a_out(a_out3), .a_valid_out(a_valid_out3), .b_out(b_out3), .b_valid_out(b_valid_out3),
    .c_out(c_out3), .c_valid_out(c_valid_out3), .ovf(ovf3), .busy(busy3));

  systolic_pe #(.CHAIN_POS(2)) u4 (
    .clk(clk), .rst(rst), .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in), .b_valid_in(b_valid_in),
    .acc_clr(acc_clr), .drain(drain), .c_in(c_in), .c_valid_in(c_valid_in),
    .a_out(a_out4), .a_valid_out(a_valid_out4), .b_out(b_out4), .b_valid_out(b_valid_out4),
    .c_out(c_out4), .c_valid_out(c_valid_out4), .ovf(ovf4), .busy(busy4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    a_in = 8'd0; b_in = 8'd0; a_valid_in = 1'b0; b_valid_in = 1'b0;
    acc_clr = 1'b0; drain = 1'b0; c_in = 32'd0; c_valid_in = 1'b0;
  endtask

  // Advance through one rising edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mac_cycle(input logic [7:0] a, input logic [7:0] b, input logic clr);
    a_in = a; b_in = b; a_valid_in = 1'b1; b_valid_in = 1'b1; acc_clr = clr;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) step();
    total++; if (outs0 !== 53'd0) begin bad++; $display("FAIL reset_outputs got=%0h exp=0", outs0); end
    rst = 1'b1;
    a_in = 8'd9; b_in = 8'd2; a_valid_in = 1'b1; b_valid_in = 1'b1; acc_clr = 1'b1; drain = 1'b1;
    step();
    idle_inputs();
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL pre_reset_busy got=%0b exp=1", busy0); end
    total++; if (c_out0 !== 32'd18) begin bad++; $display("FAIL pre_reset_c_out got=%0d exp=18", c_out0); end
    total++; if (busy4 !== 1'b1) begin bad++; $display("FAIL pre_reset_busy_chain got=%0b exp=1", busy4); end
    #3;
    rst = 1'b0;
    #1;
    total++; if (outs0 !== 53'd0) begin bad++; $display("FAIL async_reset_outputs got=%0h exp=0", outs0); end
    total++; if (outs4 !== 53'd0) begin bad++; $display("FAIL async_reset_chain got=%0h exp=0", outs4); end
    #1;
    rst = 1'b1;
  endtask

  task automatic test_basic_mac();
    mac_cycle(8'd3, 8'd4, 1'b1);
    total++; if ({a_out0, a_valid_out0, b_out0, b_valid_out0} !== {8'd3, 1'b1, 8'd4, 1'b1}) begin
      bad++; $display("FAIL pass_through_1 got=%0h/%0h exp=3/4", a_out0, b_out0); end
    mac_cycle(8'd5, 8'd6, 1'b0);
    total++; if ({a_out0, a_valid_out0, b_out0, b_valid_out0} !== {8'd5, 1'b1, 8'd6, 1'b1}) begin
      bad++; $display("FAIL pass_through_2 got=%0h/%0h exp=5/6", a_out0, b_out0); end
    drain = 1'b1;
    step();
    idle_inputs();
    total++; if ({c_valid_out0, c_out0} !== {1'b1, 32'd42}) begin
      bad++; $display("FAIL drain_42 got=%0b/%0d exp=1/42", c_valid_out0, c_out0); end
    total++; if ({busy0, a_valid_out0} !== {1'b1, 1'b0}) begin
      bad++; $display("FAIL drain_busy got=%0b/%0b exp=1/0", busy0, a_valid_out0); end
    step();
    total++; if ({c_valid_out0, busy0, c_out0} !== {1'b0, 1'b0, 32'd42}) begin
      bad++; $display("FAIL after_drain got=%0b/%0b/%0d exp=0/0/42", c_valid_out0, busy0, c_out0); end
    repeat (3) step();
  endtask

  task automatic test_signedness();
    mac_cycle(8'hFE, 8'd3, 1'b1);
    drain = 1'b1;
    step();
    idle_inputs();
    total++; if (c_out0 !== 32'hFFFF_FFFA) begin bad++; $display("FAIL signed_product got=%0h exp=fffffffa", c_out0); end
    total++; if (c_out1 !== 32'd762) begin bad++; $display("FAIL unsigned_product got=%0d exp=762", c_out1); end
    repeat (4) step();
  endtask

  task automatic test_overflow();
    mac_cycle(8'd127, 8'd127, 1'b1);
    mac_cycle(8'd127, 8'd127, 1'b0);
    total++; if (ovf2 !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0b exp=0", ovf2); end
    mac_cycle(8'd127, 8'd127, 1'b0);
    total++; if ({ovf2, ovf3, ovf0} !== {1'b1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL ovf_flags got=%0b%0b%0b exp=110", ovf2, ovf3, ovf0); end
    drain = 1'b1;
    step();
    idle_inputs();
    total++; if (c_out2 !== 16'h7FFF) begin bad++; $display("FAIL saturate got=%0h exp=7fff", c_out2); end
    total++; if (c_out3 !== 16'hBD03) begin bad++; $display("FAIL wrap got=%0h exp=bd03", c_out3); end
    total++; if (c_out0 !== 32'd48387) begin bad++; $display("FAIL wide_sum got=%0d exp=48387", c_out0); end
    step();
    total++; if ({ovf2, busy2} !== {1'b1, 1'b0}) begin
      bad++; $display("FAIL ovf_retained got=%0b/%0b exp=1/0", ovf2, busy2); end
    mac_cycle(8'd1, 8'd1, 1'b1);
    total++; if ({ovf2, ovf3} !== {1'b0, 1'b0}) begin
      bad++; $display("FAIL ovf_clear got=%0b%0b exp=00", ovf2, ovf3); end
    repeat (3) step();
  endtask

  task automatic test_chain();
    mac_cycle(8'd5, 8'd1, 1'b1);
    drain = 1'b1;
    step();
    total++; if ({c_valid_out4, busy4, c_out4} !== {1'b1, 1'b1, 32'd5}) begin
      bad++; $display("FAIL chain_first got=%0b/%0b/%0d exp=1/1/5", c_valid_out4, busy4, c_out4); end
    // Repeated drain and a valid operand pair while draining.
    drain = 1'b1; c_in = 32'd7; c_valid_in = 1'b1;
    a_in = 8'd10; b_in = 8'd10; a_valid_in = 1'b1; b_valid_in = 1'b1;
    step();
    total++; if ({c_valid_out4, busy4, c_out4} !== {1'b1, 1'b1, 32'd7}) begin
      bad++; $display("FAIL chain_second got=%0b/%0b/%0d exp=1/1/7", c_valid_out4, busy4, c_out4); end
    total++; if ({a_out4, a_valid_out4} !== {8'd10, 1'b1}) begin
      bad++; $display("FAIL drain_forward got=%0d/%0b exp=10/1", a_out4, a_valid_out4); end
    idle_inputs();
    c_in = 32'd9; c_valid_in = 1'b1;
    step();
    total++; if ({c_valid_out4, busy4, c_out4} !== {1'b1, 1'b1, 32'd9}) begin
      bad++; $display("FAIL chain_third got=%0b/%0b/%0d exp=1/1/9", c_valid_out4, busy4, c_out4); end
    idle_inputs();
    step();
    total++; if ({c_valid_out4, busy4, c_out4} !== {1'b0, 1'b0, 32'd9}) begin
      bad++; $display("FAIL chain_end got=%0b/%0b/%0d exp=0/0/9", c_valid_out4, busy4, c_out4); end
    drain = 1'b1;
    step();
    idle_inputs();
    total++; if ({c_valid_out4, c_out4} !== {1'b1, 32'd0}) begin
      bad++; $display("FAIL acc_cleared got=%0b/%0d exp=1/0", c_valid_out4, c_out4); end
    repeat (4) step();
  endtask

  task automatic test_back_to_back();
    mac_cycle(8'd2, 8'd3, 1'b1);
    a_in = 8'd4; b_in = 8'd5; a_valid_in = 1'b1; b_valid_in = 1'b1; drain = 1'b1;
    step();
    idle_inputs();
    total++; if ({c_valid_out0, c_out0} !== {1'b1, 32'd26}) begin
      bad++; $display("FAIL mac_with_drain got=%0b/%0d exp=1/26", c_valid_out0, c_out0); end
    repeat (4) step();
  endtask

  initial begin
    test_reset();
    test_basic_mac();
    test_signedness();
    test_overflow();
    test_chain();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
